// File: rtl/spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spm_seq_ctrl
// Purpose  : Sequencer for a serial-parallel multiplier (spm) CSA array.
//            Accepts an operand pair, clears the array, streams the
//            multiplier LSB first, collects the serial product bits and
//            presents the 2*WIDTH-bit product on a valid/ready port.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            in_valid/in_ready  - operand handshake (in_x, in_y)
//            spm_x/spm_y/spm_clr- parallel operand, serial bit, array clear
//            spm_p              - serial product bit from the array
//            out_valid/out_ready- result handshake (out_p)
// Revision : 1.0 - initial release
// ============================================================================
module spm_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SPM_LAT = 1,
  parameter bit SIGNED  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  output logic               spm_clr,
  input  logic               spm_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int c_RUN_LEN = 2*WIDTH + SPM_LAT;
  localparam int c_CNT_W   = $clog2(c_RUN_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_RUN_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAT  = c_CNT_W'(SPM_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic                 r_pad;
  logic [2*WIDTH-1:0]   r_p;
  logic                 w_run_last;
  logic                 w_capture;

  assign w_run_last = (r_cnt == c_CNT_LAST);
  // The first SPM_LAT run cycles only fill the array pipeline.
  assign w_capture  = (r_cnt >= c_CNT_LAT);

  assign spm_x = r_x;
  assign out_p = r_p;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    spm_clr     = rst;
    spm_y       = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        spm_clr     = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // r_y shifts right each run cycle with the pad bit entering the top,
        // so bit 0 is y[k] for k<WIDTH and the pad bit afterwards.
        spm_y = r_y[0];
        if (w_run_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A result pending when rst arrives is never offered.
        out_valid = ~rst;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_pad   <= 1'b0;
      r_p     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= in_x;
            r_y   <= in_y;
            r_pad <= SIGNED ? in_y[WIDTH-1] : 1'b0;
          end
        end
        S_CLEAR: begin
          r_cnt <= '0;
          r_p   <= '0;
        end
        S_RUN: begin
          r_y <= {r_pad, r_y[WIDTH-1:1]};
          // LSB-first product bits enter at the top; after 2*WIDTH
          // captures product bit 0 has reached out_p[0].
          if (w_capture) begin
            r_p <= {spm_p, r_p[2*WIDTH-1:1]};
          end
          // Counter stops at the terminal count; it never wraps.
          if (!w_run_last) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_seq_ctrl
// Purpose  : Self-checking bench for spm_seq_ctrl (WIDTH=8, SPM_LAT=1), one
//            unsigned and one signed instance driven by the same stimulus,
//            each connected to a behavioural serial multiplier array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spm_seq_ctrl;

  localparam int W      = 8;
  localparam int L      = 1;
  localparam int T_DONE = 2*W + L + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;

  logic        in_ready_u, in_ready_s;
  logic [7:0]  spm_x_u, spm_x_s;
  logic        spm_y_u, spm_y_s;
  logic        spm_clr_u, spm_clr_s;
  logic        spm_p_u, spm_p_s;
  logic        out_valid_u, out_valid_s;
  logic [15:0] out_p_u, out_p_s;

  int total = 0;
  int bad   = 0;

  spm_seq_ctrl #(.WIDTH(W), .SPM_LAT(L), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_x(in_x), .in_y(in_y),
    .spm_x(spm_x_u), .spm_y(spm_y_u), .spm_clr(spm_clr_u), .spm_p(spm_p_u),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_p(out_p_u)
  );

  spm_seq_ctrl #(.WIDTH(W), .SPM_LAT(L), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x), .in_y(in_y),
    .spm_x(spm_x_s), .spm_y(spm_y_s), .spm_clr(spm_clr_s), .spm_p(spm_p_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_p(out_p_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic prod_bit(input logic [15:0] x, input logic [15:0] y, input int n);
    logic [15:0] p;
    p = x * y;
    return p[n];
  endfunction

  // Behavioural array: product bit n depends only on multiplier bits 0..n,
  // emitted one cycle after spm_y bit n (latency L=1).
  logic [15:0] ya_u, ya_s;
  int          na_u, na_s;
  always @(posedge clk) begin
    if (spm_clr_u) begin
      ya_u <= '0; na_u <= 0; spm_p_u <= 1'b0;
    end else if (na_u < 16) begin
      ya_u    <= ya_u | (16'(spm_y_u) << na_u);
      spm_p_u <= prod_bit({8'h00, spm_x_u}, ya_u | (16'(spm_y_u) << na_u), na_u);
      na_u    <= na_u + 1;
    end
    if (spm_clr_s) begin
      ya_s <= '0; na_s <= 0; spm_p_s <= 1'b0;
    end else if (na_s < 16) begin
      ya_s    <= ya_s | (16'(spm_y_s) << na_s);
      spm_p_s <= prod_bit({{8{spm_x_s[7]}}, spm_x_s}, ya_s | (16'(spm_y_s) << na_s), na_s);
      na_s    <= na_s + 1;
    end
  end

  // Reference model: t counts cycles since the accept edge (-1 = idle).
  initial begin : model
    int          t;
    int          k;
    bit          armed;
    bit          pz;
    logic [7:0]  mx, my;
    logic [15:0] pu, ps;
    logic        ey_u, ey_s;
    t = -1; armed = 1'b0; pz = 1'b0; mx = '0; my = '0; pu = '0; ps = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        t = -1; armed = 1'b1; pz = 1'b1; mx = '0; my = '0;
      end else if (armed) begin
        if (t < 0) begin
          if (in_valid) begin
            t  = 1; mx = in_x; my = in_y; pz = 1'b0;
            pu = 16'({8'h00, in_x} * {8'h00, in_y});
            ps = 16'($signed({{8{in_x[7]}}, in_x}) * $signed({{8{in_y[7]}}, in_y}));
          end
        end else if (t < T_DONE) begin
          t++;
        end else if (out_ready) begin
          t = -1;
        end
      end
      #1;
      if (armed) begin
        ey_u = 1'b0; ey_s = 1'b0;
        if (t >= 2 && t <= T_DONE - 1) begin
          k    = t - 2;
          ey_u = (k < W) ? my[k] : 1'b0;
          ey_s = (k < W) ? my[k] : my[W-1];
        end
        chk("m_in_ready_u",  in_ready_u,  t < 0);
        chk("m_in_ready_s",  in_ready_s,  t < 0);
        chk("m_out_valid_u", out_valid_u, (t == T_DONE) && !rst);
        chk("m_out_valid_s", out_valid_s, (t == T_DONE) && !rst);
        chk("m_spm_clr_u",   spm_clr_u,   rst || (t == 1));
        chk("m_spm_clr_s",   spm_clr_s,   rst || (t == 1));
        chk("m_spm_y_u",     spm_y_u,     ey_u);
        chk("m_spm_y_s",     spm_y_s,     ey_s);
        chk("m_spm_x_u",     spm_x_u,     mx);
        chk("m_spm_x_s",     spm_x_s,     mx);
        if (t == T_DONE) begin
          chk("m_out_p_u", out_p_u, pu);
          chk("m_out_p_s", out_p_s, ps);
        end else if (t < 0 && pz) begin
          chk("m_out_p_u_rst", out_p_u, 16'h0);
          chk("m_out_p_s_rst", out_p_s, 16'h0);
        end
      end
    end
  end

  // One operation; if bp, the next operand pair (0x12,0x34) is offered
  // during the backpressure hold and left valid after the handshake.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] eu, input logic [15:0] es,
                        input int hold, input bit bp);
    int cyc;
    cyc = 0;
    while (!in_ready_u && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_in_ready", in_ready_u, 1'b1);
    in_x = x; in_y = y; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_x = ~x; in_y = ~y;
    chk("clr_after_accept", spm_clr_u, 1'b1);
    cyc = 1;
    while (!out_valid_u && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, T_DONE);
    if (bp) begin
      in_valid = 1'b1; in_x = 8'h12; in_y = 8'h34;
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", out_valid_u, 1'b1);
      chk("hold_p_u", out_p_u, eu);
      chk("hold_in_ready", in_ready_u, 1'b0);
    end
    chk("p_u", out_p_u, eu);
    chk("p_s", out_p_s, es);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bubble_idle", in_ready_u, 1'b1);
  endtask

  initial begin : stim
    int nres;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_spm_clr", spm_clr_u, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready_u, 1'b1);
    chk("rst_out_valid", out_valid_u, 1'b0);
    chk("rst_out_p", out_p_u, 16'h0);
    chk("idle_spm_clr", spm_clr_u, 1'b0);

    run_op(8'h03, 8'h05, 16'h000F, 16'h000F, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 16'hFE01, 16'h0001, 0, 1'b0);
    run_op(8'h00, 8'hA5, 16'h0000, 16'h0000, 0, 1'b0);
    run_op(8'h80, 8'h02, 16'h0100, 16'hFF00, 0, 1'b0);
    run_op(8'h7F, 8'h81, 16'h3FFF, 16'hC0FF, 5, 1'b1);
    run_op(8'h12, 8'h34, 16'h03A8, 16'h03A8, 0, 1'b0);

    // Reset in the middle of a run (RUN count 6 = cycle 8 after accept).
    in_x = 8'h55; in_y = 8'h33; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_in_ready", in_ready_u, 1'b1);
    chk("mr_out_valid", out_valid_u, 1'b0);
    chk("mr_out_p", out_p_u, 16'h0);
    chk("mr_spm_x", spm_x_u, 8'h00);
    run_op(8'h07, 8'h09, 16'h003F, 16'h003F, 0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    nres = 0;
    in_x = 8'h0B; in_y = 8'h0D; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_x = 8'hF0; in_y = 8'h0F;
      end
      if (out_valid_u) begin
        if (nres == 0) begin
          chk("b2b_t0", c, 19);
          chk("b2b_p0_u", out_p_u, 16'h008F);
          chk("b2b_p0_s", out_p_s, 16'h008F);
        end else begin
          chk("b2b_t1", c, 39);
          chk("b2b_p1_u", out_p_u, 16'h0E10);
          chk("b2b_p1_s", out_p_s, 16'hFF10);
          in_valid = 1'b0;
        end
        nres++;
      end
      if (nres == 2) break;
    end
    chk("b2b_count", nres, 2);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
